rx_packet_stats: RTL and testbench

Passive, parametrised receive-statistics monitor for a 512-bit (default) AXI-Stream link. Taps an existing valid/ready handshake without driving it. Classifies each completed packet into one of NBINS runtime-programmable length bins, an "other" bin, or a "bad" bin (tuser). Also accumulates good-packet bytes and maximum length, and exposes all statistics through an atomic snapshot/clear interface for the register block.

---
 rtl/rx_packet_stats.sv | 157 +++++++++++++++
 tb/tb_rx_packet_stats.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_stats.sv
// rx_packet_stats: passive AXI-Stream receive monitor. Bins completed packets by
// length, counts bad packets, bytes and max length, with atomic snapshot/clear.
module rx_packet_stats #(
  parameter int DW    = 512,
  parameter int NBINS = 4,
  parameter int CW    = 64,
  parameter int LW    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [DW-1:0]       mon_tdata,
  input  logic [DW/8-1:0]     mon_tkeep,
  input  logic                mon_tlast,
  input  logic                mon_tuser,
  input  logic                mon_tvalid,
  input  logic                mon_tready,
  input  logic [NBINS*LW-1:0] bin_len,
  input  logic                snap_req,
  input  logic                clear_req,
  output logic [NBINS*CW-1:0] snap_bins,
  output logic [CW-1:0]       snap_other,
  output logic [CW-1:0]       snap_bad,
  output logic [CW-1:0]       snap_bytes,
  output logic [LW-1:0]       snap_max_len,
  output logic                snap_valid
);

  localparam int KW  = DW / 8;
  localparam int BCW = $clog2(KW) + 1;
  localparam int SW  = ((CW > LW) ? CW : LW) + 1;

  logic           tdata_unused;
  logic [BCW-1:0] keep_cnt;
  logic           beat_q;
  logic           last_q;
  logic           user_q;
  logic [BCW-1:0] bcnt_q;

  logic [LW-1:0]    partial_q;
  logic [LW:0]      len_sum;
  logic [LW-1:0]    pkt_len;
  logic             len_sat;
  logic             pkt_done;
  logic [NBINS-1:0] bin_match;
  logic [NBINS-1:0] bin_hit;

  logic [CW-1:0] bin_cnt [NBINS];
  logic [CW-1:0] other_cnt;
  logic [CW-1:0] bad_cnt;
  logic [CW-1:0] bytes_cnt;
  logic [LW-1:0] max_len;
  logic [SW-1:0] bytes_sum;

  assign tdata_unused = ^mon_tdata;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) begin
      keep_cnt = keep_cnt + BCW'(mon_tkeep[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_q <= 1'b0;
      last_q <= 1'b0;
      user_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beat_q <= mon_tvalid & mon_tready;
      last_q <= mon_tlast;
      user_q <= mon_tuser;
      bcnt_q <= keep_cnt;
    end
  end

  // A length pinned at all-ones is treated as saturated and never hits a bin.
  always_comb begin
    len_sum   = {1'b0, partial_q} + (LW+1)'(bcnt_q);
    pkt_len   = len_sum[LW] ? {LW{1'b1}} : len_sum[LW-1:0];
    len_sat   = &pkt_len;
    pkt_done  = beat_q & last_q;
    bin_match = '0;
    for (int i = 0; i < NBINS; i++) begin
      bin_match[i] = (bin_len[i*LW +: LW] != '0) &&
                     (bin_len[i*LW +: LW] == pkt_len) && !len_sat;
    end
    bin_hit = bin_match & ~(bin_match - NBINS'(1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      partial_q <= '0;
    end else if (beat_q) begin
      partial_q <= last_q ? '0 : pkt_len;
    end
  end

  assign bytes_sum = SW'(bytes_cnt) + SW'(pkt_len);

  // Clear wins over a classification landing on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn || clear_req) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_cnt[i] <= '0;
      end
      other_cnt <= '0;
      bad_cnt   <= '0;
      bytes_cnt <= '0;
      max_len   <= '0;
    end else if (pkt_done) begin
      if (user_q) begin
        bad_cnt <= sat_inc(bad_cnt);
      end else begin
        for (int i = 0; i < NBINS; i++) begin
          if (bin_hit[i]) begin
            bin_cnt[i] <= sat_inc(bin_cnt[i]);
          end
        end
        if (bin_hit == '0) begin
          other_cnt <= sat_inc(other_cnt);
        end
        bytes_cnt <= (|bytes_sum[SW-1:CW]) ? {CW{1'b1}} : bytes_sum[CW-1:0];
        if (pkt_len > max_len) begin
          max_len <= pkt_len;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap_bins    <= '0;
      snap_other   <= '0;
      snap_bad     <= '0;
      snap_bytes   <= '0;
      snap_max_len <= '0;
      snap_valid   <= 1'b0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        for (int i = 0; i < NBINS; i++) begin
          snap_bins[i*CW +: CW] <= bin_cnt[i];
        end
        snap_other   <= other_cnt;
        snap_bad     <= bad_cnt;
        snap_bytes   <= bytes_cnt;
        snap_max_len <= max_len;
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_stats.sv
// tb_rx_packet_stats: directed stimulus for rx_packet_stats, checked against a
// packet-level statistics model plus hand-computed snapshot values.
module tb_rx_packet_stats;

  localparam int DW = 512, NBINS = 4, CW = 64, LW = 16, KW = DW / 8;
  localparam int S_NBINS = 2, S_CW = 4, S_LW = 8;
  localparam longint unsigned LMAX = (64'd1 << LW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [DW-1:0]       mon_tdata;
  logic [KW-1:0]       mon_tkeep;
  logic                mon_tlast, mon_tuser, mon_tvalid, mon_tready;
  logic [NBINS*LW-1:0] bin_len;
  logic                snap_req, clear_req;
  logic [NBINS*CW-1:0] snap_bins;
  logic [CW-1:0]       snap_other, snap_bad, snap_bytes;
  logic [LW-1:0]       snap_max_len;
  logic                snap_valid;

  logic [S_NBINS*S_LW-1:0] s_bin_len;
  logic [S_NBINS*S_CW-1:0] s_snap_bins;
  logic [S_CW-1:0]         s_snap_other, s_snap_bad, s_snap_bytes;
  logic [S_LW-1:0]         s_snap_max_len;
  logic                    s_snap_valid;

  int tests_run = 0;
  int tests_failed = 0;

  rx_packet_stats #(.DW(DW), .NBINS(NBINS), .CW(CW), .LW(LW)) dut (
    .clk(clk), .resetn(resetn), .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep),
    .mon_tlast(mon_tlast), .mon_tuser(mon_tuser), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .bin_len(bin_len), .snap_req(snap_req),
    .clear_req(clear_req), .snap_bins(snap_bins), .snap_other(snap_other),
    .snap_bad(snap_bad), .snap_bytes(snap_bytes), .snap_max_len(snap_max_len),
    .snap_valid(snap_valid)
  );

  // Narrow instance sharing the stream, used to reach counter and length saturation.
  rx_packet_stats #(.DW(DW), .NBINS(S_NBINS), .CW(S_CW), .LW(S_LW)) dut_small (
    .clk(clk), .resetn(resetn), .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep),
    .mon_tlast(mon_tlast), .mon_tuser(mon_tuser), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .bin_len(s_bin_len), .snap_req(snap_req),
    .clear_req(clear_req), .snap_bins(s_snap_bins), .snap_other(s_snap_other),
    .snap_bad(s_snap_bad), .snap_bytes(s_snap_bytes), .snap_max_len(s_snap_max_len),
    .snap_valid(s_snap_valid)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  longint unsigned m_bins [NBINS];
  longint unsigned m_other, m_bad, m_bytes, m_max;
  longint unsigned e_bins [NBINS];
  longint unsigned e_other, e_bad, e_bytes, e_max;
  bit              e_valid;
  longint unsigned m_part, p_len;
  bit              p_v, p_user;
  int              hit;

  // Packet-level model: a packet whose tlast is accepted on one edge is
  // counted on the following edge unless that edge clears or resets.
  always @(posedge clk) begin
    if (!resetn) begin
      foreach (m_bins[i]) begin m_bins[i] = 0; e_bins[i] = 0; end
      m_other = 0; m_bad = 0; m_bytes = 0; m_max = 0;
      e_other = 0; e_bad = 0; e_bytes = 0; e_max = 0;
      e_valid = 0; p_v = 0; m_part = 0;
    end else begin
      e_valid = snap_req;
      if (snap_req) begin
        e_bins = m_bins; e_other = m_other; e_bad = m_bad;
        e_bytes = m_bytes; e_max = m_max;
      end
      if (p_v && !clear_req) begin
        if (p_user) m_bad++;
        else begin
          hit = -1;
          for (int i = 0; i < NBINS; i++)
            if (hit < 0 && bin_len[i*LW +: LW] != 0 && p_len == bin_len[i*LW +: LW] && p_len != LMAX)
              hit = i;
          if (hit >= 0) m_bins[hit]++; else m_other++;
          m_bytes += p_len;
          if (p_len > m_max) m_max = p_len;
        end
      end
      if (clear_req) begin
        foreach (m_bins[i]) m_bins[i] = 0;
        m_other = 0; m_bad = 0; m_bytes = 0; m_max = 0;
      end
      p_v = 0;
      if (mon_tvalid && mon_tready) begin
        m_part = m_part + $countones(mon_tkeep);
        if (m_part > LMAX) m_part = LMAX;
        if (mon_tlast) begin
          p_v = 1; p_len = m_part; p_user = mon_tuser; m_part = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("snap_valid", {63'd0, snap_valid}, {63'd0, e_valid});
    if (e_valid) begin
      for (int i = 0; i < NBINS; i++)
        check_output($sformatf("model snap_bins[%0d]", i), snap_bins[i*CW +: CW], e_bins[i]);
      check_output("model snap_other", snap_other, e_other);
      check_output("model snap_bad", snap_bad, e_bad);
      check_output("model snap_bytes", snap_bytes, e_bytes);
      check_output("model snap_max_len", {48'd0, snap_max_len}, e_max);
    end
  end

  task automatic beat(input logic [KW-1:0] keep, input logic last, input logic user);
    @(negedge clk);
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tkeep = keep;
    mon_tlast = last; mon_tuser = user; mon_tdata = {16{$urandom}};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      mon_tuser = 1'b0; mon_tkeep = '0;
    end
  endtask

  function automatic logic [KW-1:0] keep_for(input int n);
    logic [KW-1:0] ones = '1;
    return ones >> (KW - n);
  endfunction

  task automatic apply_stimulus(input int nbytes, input logic user);
    int left = nbytes;
    while (left > 0) begin
      int n;
      n = (left > KW) ? KW : left;
      left -= n;
      beat(keep_for(n), left == 0, (left == 0) ? user : 1'b0);
    end
    idle(2);
  endtask

  task automatic take_snapshot(input logic clr);
    @(negedge clk);
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    snap_req = 1'b1; clear_req = clr;
    @(negedge clk);
    snap_req = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; mon_tdata = '0; mon_tkeep = '0; mon_tlast = 1'b0; mon_tuser = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; snap_req = 1'b0; clear_req = 1'b0;
    bin_len = {16'd0, 16'd4160, 16'd192, 16'd68};
    s_bin_len = {8'd3, 8'd255};
    repeat (3) @(negedge clk);
    check_output("reset snap_valid", {63'd0, snap_valid}, 64'd0);
    check_output("reset snap_bytes", snap_bytes, 64'd0);
    check_output("reset snap_max_len", {48'd0, snap_max_len}, 64'd0);
    resetn = 1'b1;
    idle(2);

    apply_stimulus(4160, 1'b0);
    apply_stimulus(192, 1'b0);
    apply_stimulus(68, 1'b0);
    take_snapshot(1'b1);
    check_output("mix bin0", snap_bins[0*CW +: CW], 64'd1);
    check_output("mix bin1", snap_bins[1*CW +: CW], 64'd1);
    check_output("mix bin2", snap_bins[2*CW +: CW], 64'd1);
    check_output("mix bin3", snap_bins[3*CW +: CW], 64'd0);
    check_output("mix other", snap_other, 64'd0);
    check_output("mix bytes", snap_bytes, 64'd4420);
    check_output("mix max_len", {48'd0, snap_max_len}, 64'd4160);

    apply_stimulus(4160, 1'b1);
    take_snapshot(1'b1);
    check_output("bad count", snap_bad, 64'd1);
    check_output("bad bin2", snap_bins[2*CW +: CW], 64'd0);
    check_output("bad bytes", snap_bytes, 64'd0);

    bin_len = {16'd0, 16'd0, 16'd100, 16'd100};
    apply_stimulus(100, 1'b0);
    take_snapshot(1'b0);
    check_output("dup bin0", snap_bins[0*CW +: CW], 64'd1);
    check_output("dup bin1", snap_bins[1*CW +: CW], 64'd0);
    apply_stimulus(101, 1'b0);
    take_snapshot(1'b1);
    check_output("dup other", snap_other, 64'd1);
    check_output("dup bytes", snap_bytes, 64'd201);

    beat(64'h5, 1'b1, 1'b0);
    idle(2);
    take_snapshot(1'b1);
    check_output("sparse other", snap_other, 64'd1);
    check_output("sparse max_len", {48'd0, snap_max_len}, 64'd2);

    // Fourth packet's classification lands on the snapshot+clear edge.
    repeat (3) apply_stimulus(100, 1'b0);
    beat(64'h1, 1'b1, 1'b0);
    @(negedge clk);
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    snap_req = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0; clear_req = 1'b0;
    check_output("atomic bin0", snap_bins[0*CW +: CW], 64'd3);
    check_output("atomic bytes", snap_bytes, 64'd300);
    idle(2);
    take_snapshot(1'b0);
    check_output("post-clear bin0", snap_bins[0*CW +: CW], 64'd0);
    check_output("post-clear other", snap_other, 64'd0);
    check_output("post-clear bytes", snap_bytes, 64'd0);

    bin_len = {16'd0, 16'd4160, 16'd192, 16'd68};
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tkeep = '1; mon_tlast = (b == 2);
      @(negedge clk);
      mon_tready = 1'b1;
    end
    idle(2);
    take_snapshot(1'b1);
    check_output("throttle bin1", snap_bins[1*CW +: CW], 64'd1);
    check_output("throttle bytes", snap_bytes, 64'd192);

    bin_len = {16'd0, 16'd0, 16'd0, 16'd64};
    for (int i = 0; i < 10; i++) beat('1, 1'b1, 1'b0);
    idle(2);
    @(negedge clk); snap_req = 1'b1; clear_req = 1'b0;
    @(negedge clk); snap_req = 1'b1; clear_req = 1'b1;
    @(negedge clk); snap_req = 1'b0; clear_req = 1'b0;
    check_output("burst bin0", snap_bins[0*CW +: CW], 64'd10);
    check_output("burst bytes", snap_bytes, 64'd640);

    bin_len = {16'd0, 16'd0, 16'd0, 16'd128};
    beat('1, 1'b0, 1'b0);
    beat('1, 1'b0, 1'b0);
    @(negedge clk); mon_tvalid = 1'b0; resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    beat('1, 1'b0, 1'b0);
    beat('1, 1'b1, 1'b0);
    idle(2);
    take_snapshot(1'b1);
    check_output("reset-mid bin0", snap_bins[0*CW +: CW], 64'd1);
    check_output("reset-mid bytes", snap_bytes, 64'd128);

    take_snapshot(1'b1);
    for (int i = 0; i < 16; i++) beat(64'h7, 1'b1, 1'b0);
    idle(2);
    take_snapshot(1'b0);
    check_output("sat bin1", {60'd0, s_snap_bins[1*S_CW +: S_CW]}, 64'd15);
    check_output("sat bin0", {60'd0, s_snap_bins[0*S_CW +: S_CW]}, 64'd0);
    check_output("sat bytes", {60'd0, s_snap_bytes}, 64'd15);
    check_output("sat max_len", {56'd0, s_snap_max_len}, 64'd3);
    apply_stimulus(256, 1'b0);
    take_snapshot(1'b1);
    check_output("satlen other", {60'd0, s_snap_other}, 64'd1);
    check_output("satlen bin0", {60'd0, s_snap_bins[0*S_CW +: S_CW]}, 64'd0);
    check_output("satlen max_len", {56'd0, s_snap_max_len}, 64'd255);
    check_output("satlen bytes", {60'd0, s_snap_bytes}, 64'd15);
    check_output("small snap_valid", {63'd0, s_snap_valid}, 64'd1);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
